// File: rtl/vga_screen_pkg.sv
// ---------------------------------------------------------------------------
// vga_screen_pkg
//
// This package holds the types and defaults shared by the screen-select
// controllers that drive the VGA source mux.
//
// Contents:
//   screen_state_t   2-bit sequencer state: ST_GAME=0, ST_WIN_PEND=1,
//                    ST_WIN_SHOW=2, ST_GAME_PEND=3. A later extension, such
//                    as a lose screen, can add its own states here.
//   DEF_*            default frame counts and counter width.
//   shows_win()      reports whether a state has the win renderer on the mux.
// ---------------------------------------------------------------------------
package vga_screen_pkg;

    typedef enum logic [1:0] {
        ST_GAME      = 2'd0,
        ST_WIN_PEND  = 2'd1,
        ST_WIN_SHOW  = 2'd2,
        ST_GAME_PEND = 2'd3
    } screen_state_t;

    localparam int unsigned DEF_HOLD_FRAMES = 180;  // 3 s at 60 Hz
    localparam int unsigned DEF_MIN_FRAMES  = 30;
    localparam int unsigned DEF_CNT_W       = 8;

    // GAME_PEND keeps the win screen on the mux. The game screen only
    // returns at the next frame boundary.
    function automatic logic shows_win(input screen_state_t s);
        return (s == ST_WIN_SHOW) || (s == ST_GAME_PEND);
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// ---------------------------------------------------------------------------
// vga_frame_tick
//
// This module is the frame-boundary detector. It produces a single-cycle
// tick when the active-low vertical sync falls. Any frame-synchronous block
// can reuse it.
//
// Ports:
//   clk     in   system clock; this is also the sync generator domain
//   resetn  in   synchronous active-low reset
//   vga_vs  in   vertical sync, active low
//   fe      out  combinational tick, high in the cycle vga_vs first goes low
// ---------------------------------------------------------------------------
module vga_frame_tick (
    input  logic clk,
    input  logic resetn,
    input  logic vga_vs,
    output logic fe
);

    logic r_vs_d;

    // The register resets to 1, the idle level of the sync, so the release
    // of reset never creates a false tick.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vs_d <= 1'b1;
        end else begin
            r_vs_d <= vga_vs;
        end
    end

    assign fe = r_vs_d & ~vga_vs;

endmodule

// File: rtl/vga_screen_ctrl.sv
// ---------------------------------------------------------------------------
// vga_screen_ctrl
//
// This module sequences the `win` select of the VGA source mux between the
// game renderer and the win-screen renderer.
//
// Behaviour:
//   - The screen changes only on the falling edge of vertical sync, so no
//     frame is torn.
//   - The win screen is held for HOLD_FRAMES frames. A continue request
//     ends it early, but only after MIN_FRAMES frames.
//   - The game is paused for the whole sequence.
//   - A one-cycle restart pulse is issued when the game screen returns.
//
// Parameters (HOLD_FRAMES < 2**CNT_W, MIN_FRAMES <= HOLD_FRAMES):
//   HOLD_FRAMES  frames shown before the automatic return to the game
//   MIN_FRAMES   frames that must elapse before continue_req is honoured
//   CNT_W        frame counter width
//
// Ports:
//   clk           in   system clock (VGA sync domain)
//   resetn        in   synchronous active-low reset
//   win_event     in   one-cycle pulse: the player has won
//   continue_req  in   debounced level: leave the win screen early
//   vga_vs        in   vertical sync of the selected source, active low
//   win           out  mux select, 1 = win screen
//   game_pause    out  freezes game state updates
//   game_restart  out  one-cycle pulse when the game screen is back
//   frame_cnt     out  frames shown on the win screen so far
//   busy          out  high in every state except GAME
// ---------------------------------------------------------------------------
module vga_screen_ctrl
    import vga_screen_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int unsigned MIN_FRAMES  = DEF_MIN_FRAMES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             win_event,
    input  logic             continue_req,
    input  logic             vga_vs,
    output logic             win,
    output logic             game_pause,
    output logic             game_restart,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_FRAMES);

    screen_state_t    r_state;
    screen_state_t    w_state_nxt;
    logic             r_win;
    logic             w_win_nxt;
    logic             r_pause;
    logic             w_pause_nxt;
    logic             r_restart;
    logic             w_restart_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_frame_cnt_nxt;

    logic             w_fe;
    logic             w_hold_done;
    logic             w_early_exit;

    vga_frame_tick u_frame_tick (
        .clk    (clk),
        .resetn (resetn),
        .vga_vs (vga_vs),
        .fe     (w_fe)
    );

    // These exit terms use the registered count, so the decision always
    // refers to frames that have already been shown.
    assign w_hold_done  = (r_frame_cnt == HOLD_C);
    assign w_early_exit = continue_req && (r_frame_cnt >= MIN_C);

    // -----------------------------------------------------------------------
    // This block computes the next state and the next output values.
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, which prevents
    // latches from being inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_restart_nxt   = 1'b0;

        case (r_state)
            // A win_event in a tick cycle only arms WIN_PEND. The screen
            // still waits for a later frame boundary.
            ST_GAME: begin
                if (win_event) begin
                    w_state_nxt = ST_WIN_PEND;
                end
            end

            ST_WIN_PEND: begin
                if (w_fe) begin
                    w_state_nxt     = ST_WIN_SHOW;
                    w_frame_cnt_nxt = '0;
                end
            end

            // The count saturates at HOLD_FRAMES and never wraps.
            // continue_req is sampled as a level and is not latched.
            ST_WIN_SHOW: begin
                if (w_fe && !w_hold_done) begin
                    w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                end
                if (w_hold_done || w_early_exit) begin
                    w_state_nxt = ST_GAME_PEND;
                end
            end

            ST_GAME_PEND: begin
                if (w_fe) begin
                    w_state_nxt     = ST_GAME;
                    w_frame_cnt_nxt = '0;
                    w_restart_nxt   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_GAME;
            end
        endcase

        // The outputs are derived from the state being entered, so each
        // registered output lines up with r_state exactly.
        w_win_nxt   = shows_win(w_state_nxt);
        w_pause_nxt = (w_state_nxt != ST_GAME);
        w_busy_nxt  = (w_state_nxt != ST_GAME);
    end

    // -----------------------------------------------------------------------
    // This block holds the state and the registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_GAME;
            r_win       <= 1'b0;
            r_pause     <= 1'b0;
            r_restart   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_win       <= w_win_nxt;
            r_pause     <= w_pause_nxt;
            r_restart   <= w_restart_nxt;
            r_busy      <= w_busy_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    assign win          = r_win;
    assign game_pause   = r_pause;
    assign game_restart = r_restart;
    assign frame_cnt    = r_frame_cnt;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vga_screen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_screen_ctrl
//
// This bench drives directed stimulus against vga_screen_ctrl with
// HOLD_FRAMES=4, MIN_FRAMES=2, CNT_W=8, and one vga_vs low pulse every
// 20 clocks.
//
// On each falling clock edge, a behavioural model of the screen sequence is
// compared with every DUT output. The model tracks two facts:
//   - whether a win screen is wanted
//   - whether the win screen is on the monitor
// Literal checks at key moments pin the model itself.
// ---------------------------------------------------------------------------
module tb_vga_screen_ctrl;

    localparam int HOLD      = 4;
    localparam int MIN       = 2;
    localparam int CNT_W     = 8;
    localparam int FRAME_LEN = 20;

    logic             clk          = 1'b0;
    logic             resetn       = 1'b0;
    logic             win_event    = 1'b0;
    logic             continue_req = 1'b0;
    logic             vga_vs       = 1'b1;
    logic             win;
    logic             game_pause;
    logic             game_restart;
    logic [CNT_W-1:0] frame_cnt;
    logic             busy;

    int n_tests   = 0;
    int n_fail    = 0;
    int phase     = 2;   // position inside the frame; vga_vs is low at 0 and 1
    int rs_count  = 0;   // game_restart pulses seen so far
    int rs_before = 0;

    // Model state: "wanted" is the win screen requested; "on" is the win
    // screen visible on the monitor.
    bit m_want    = 1'b0;
    bit m_on      = 1'b0;
    bit m_restart = 1'b0;
    bit m_vs_d    = 1'b1;
    int m_frames  = 0;

    vga_screen_ctrl #(
        .HOLD_FRAMES (HOLD),
        .MIN_FRAMES  (MIN),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .win_event    (win_event),
        .continue_req (continue_req),
        .vga_vs       (vga_vs),
        .win          (win),
        .game_pause   (game_pause),
        .game_restart (game_restart),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // This task advances one clock. Inputs change 1 ns after the edge, and
    // the outputs seen afterwards are those from that edge.
    task automatic step(input logic we, input logic cr);
        @(posedge clk);
        #1;
        phase        = (phase == FRAME_LEN - 1) ? 0 : phase + 1;
        vga_vs       = (phase >= 2);
        win_event    = we;
        continue_req = cr;
    endtask

    // This task runs up to and including the edge that sees the next vga_vs
    // fall. The bound is one frame.
    task automatic next_fe(input logic cr);
        do step(1'b0, cr); while (phase != 0);
        step(1'b0, cr);
    endtask

    // -----------------------------------------------------------------------
    // This process compares against the model on each falling edge, then
    // steps the model. The model consumes the inputs that the next rising
    // edge will sample.
    // -----------------------------------------------------------------------
    initial begin : model_compare
        bit fe;
        bit leave;
        forever begin
            @(negedge clk);
            check("model win",          win,          m_on);
            check("model game_pause",   game_pause,   m_want || m_on);
            check("model busy",         busy,         m_want || m_on);
            check("model game_restart", game_restart, m_restart);
            check("model frame_cnt",    frame_cnt,    m_frames);
            if (game_restart) rs_count++;

            fe        = m_vs_d && !vga_vs;
            m_restart = 1'b0;
            if (!resetn) begin
                m_want   = 1'b0;
                m_on     = 1'b0;
                m_frames = 0;
                m_vs_d   = 1'b1;
            end else begin
                m_vs_d = vga_vs;
                if (!m_want && !m_on) begin
                    if (win_event) m_want = 1'b1;
                end else if (m_want && !m_on) begin
                    if (fe) begin
                        m_on     = 1'b1;
                        m_frames = 0;
                    end
                end else if (m_want && m_on) begin
                    leave = (m_frames == HOLD) || (continue_req && m_frames >= MIN);
                    if (fe && m_frames < HOLD) m_frames++;
                    if (leave) m_want = 1'b0;
                end else begin
                    if (fe) begin
                        m_on      = 1'b0;
                        m_frames  = 0;
                        m_restart = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Directed stimulus and literal checks.
    // -----------------------------------------------------------------------
    initial begin : stimulus
        // Reset, then 100 idle clocks.
        repeat (3) step(1'b0, 1'b0);
        check("reset win",        win,          0);
        check("reset game_pause", game_pause,   0);
        check("reset busy",       busy,         0);
        check("reset restart",    game_restart, 0);
        check("reset frame_cnt",  frame_cnt,    0);
        resetn = 1'b1;
        repeat (100) step(1'b0, 1'b0);
        check("idle win",        win,        0);
        check("idle game_pause", game_pause, 0);
        check("idle busy",       busy,       0);
        check("idle restarts",   rs_count,   0);

        // A win_event well before a frame edge runs the full automatic hold.
        while (phase != 5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("pend game_pause", game_pause, 1);
        check("pend busy",       busy,       1);
        check("pend win",        win,        0);
        next_fe(1'b0);
        check("show win",       win,       1);
        check("show frame_cnt", frame_cnt, 0);
        for (int k = 1; k <= HOLD; k++) begin
            next_fe(1'b0);
            check("hold frame_cnt", frame_cnt, k);
            check("hold win",       win,       1);
        end
        step(1'b0, 1'b0);
        check("game_pend win",  win,  1);
        check("game_pend busy", busy, 1);
        rs_before = rs_count;
        next_fe(1'b0);
        check("return win",        win,          0);
        check("return restart",    game_restart, 1);
        check("return game_pause", game_pause,   0);
        check("return busy",       busy,         0);
        check("return frame_cnt",  frame_cnt,    0);
        step(1'b0, 1'b0);
        check("restart width", game_restart, 0);
        check("restart count", rs_count - rs_before, 1);

        // An early exit on continue_req is honoured only once frame_cnt
        // reaches MIN.
        step(1'b1, 1'b0);
        next_fe(1'b0);
        next_fe(1'b0);
        check("cont cnt1", frame_cnt, 1);
        next_fe(1'b1);
        check("cont no early exit cnt", frame_cnt, 2);
        check("cont no early exit win", win,       1);
        step(1'b0, 1'b1);
        check("cont game_pend win", win,       1);
        check("cont game_pend cnt", frame_cnt, 2);
        next_fe(1'b1);
        check("cont return win",     win,          0);
        check("cont return restart", game_restart, 1);
        check("cont return busy",    busy,         0);
        step(1'b0, 1'b0);

        // A win_event in the same cycle as the frame edge cannot use that edge.
        while (phase != FRAME_LEN - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("same-fe win",  win,  0);
        check("same-fe busy", busy, 1);
        next_fe(1'b0);
        check("same-fe later win", win, 1);

        // Extra win_events in WIN_SHOW and in GAME_PEND are dropped.
        next_fe(1'b0);
        next_fe(1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("dup show cnt", frame_cnt, 2);
        check("dup show win", win,       1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        rs_before = rs_count;
        next_fe(1'b0);
        check("dup return restart", game_restart, 1);
        repeat (30) step(1'b0, 1'b0);
        check("dup restart count", rs_count - rs_before, 1);
        check("dup busy",          busy,       0);
        check("dup win",           win,        0);
        check("dup game_pause",    game_pause, 0);

        // A one-cycle reset in WIN_SHOW with frame_cnt = 3.
        step(1'b1, 1'b0);
        next_fe(1'b0);
        repeat (3) next_fe(1'b0);
        check("pre-reset cnt", frame_cnt, 3);
        resetn = 1'b0;
        step(1'b0, 1'b0);
        resetn = 1'b1;
        check("mid-reset win",        win,        0);
        check("mid-reset frame_cnt",  frame_cnt,  0);
        check("mid-reset game_pause", game_pause, 0);
        check("mid-reset busy",       busy,       0);
        repeat (25) step(1'b0, 1'b0);
        check("post-reset win",  win,  0);
        check("post-reset busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_screen_ctrl.md
Name: vga_screen_ctrl

Overview:
- Sequencer that drives the `win` select input of the VGA source mux, choosing between the game renderer and the win-screen renderer.
- Screen changes happen only at a frame boundary (falling edge of vertical sync), so no torn frame reaches the monitor.
- Holds the win screen for a programmed number of frames, with early exit on a continue request.
- Pauses the game logic while the win screen is shown and issues a one-cycle restart pulse on return.

Parameters:
- HOLD_FRAMES, 180, frames the win screen is shown before an automatic return to the game (3 s at 60 Hz).
- MIN_FRAMES, 30, frames that must elapse before `continue_req` is honoured.
- CNT_W, 8, frame counter width; must satisfy HOLD_FRAMES < 2^CNT_W and MIN_FRAMES <= HOLD_FRAMES.

Ports:
- clk  input  1  system clock; the VGA sync generators run on this domain.
- resetn  input  1  synchronous, active-low reset.
- win_event  input  1  one-cycle pulse from game logic: the player has won.
- continue_req  input  1  level, debounced key: leave the win screen early.
- vga_vs  input  1  vertical sync of the currently selected source, active low.
- win  output  1  mux select: 1 = win screen, 0 = game.
- game_pause  output  1  freezes game state updates.
- game_restart  output  1  one-cycle pulse: the game screen is back, reinitialise the level.
- frame_cnt  output  CNT_W  frames shown on the win screen so far.
- busy  output  1  high in every state except GAME.

Behaviour:
- Single clock. Every register is reset synchronously when resetn = 0 at a clk edge.
- Reset values: win = 0, game_pause = 0, game_restart = 0, frame_cnt = 0, busy = 0, state = GAME, vs_d = 1.
- Frame tick (`fe`):
  - vs_d is a register holding the previous vga_vs.
  - fe = vs_d & ~vga_vs, combinational, valid in the same cycle as the falling edge.
  - fe is the only event that may change `win`.
- All outputs are registered.
- State GAME:
  - win = 0, game_pause = 0.
  - win_event = 1 -> WIN_PEND, game_pause = 1 from the next cycle.
  - A win_event arriving in the same cycle as fe still goes to WIN_PEND; it does not use that fe.
- State WIN_PEND:
  - Waits for fe.
  - On fe: win = 1 from the next cycle, frame_cnt = 0, go to WIN_SHOW.
  - win_event is ignored.
- State WIN_SHOW:
  - Each fe increments frame_cnt, saturating at HOLD_FRAMES.
  - Exit condition: (frame_cnt == HOLD_FRAMES) OR (continue_req = 1 AND frame_cnt >= MIN_FRAMES) -> GAME_PEND.
  - continue_req while frame_cnt < MIN_FRAMES is ignored; it is not latched.
  - win_event is ignored.
- State GAME_PEND:
  - Waits for fe.
  - On fe, next cycle: win = 0, game_restart = 1 for exactly one cycle, game_pause = 0, frame_cnt = 0, state = GAME.
  - win_event in GAME_PEND is dropped.
- Latency from win_event to win = 1: 1 cycle to WIN_PEND, then the next fe, plus 1 cycle. At least 2 cycles; at most one frame plus 2 cycles.
- If vga_vs stays stuck, the controller waits indefinitely; there is no timeout.
- Reset mid-operation, in any state: next cycle win = 0, game_pause = 0, state = GAME. The frame on screen may be torn; this is accepted.
- busy = (state != GAME), registered.
- Counter arithmetic is unsigned CNT_W bits. Saturation means frame_cnt never wraps.

Decomposition:
- Shared package vga_screen_pkg:
  - 2-bit state encoding constants: ST_GAME = 0, ST_WIN_PEND = 1, ST_WIN_SHOW = 2, ST_GAME_PEND = 3.
  - Shared with a future screen-select extension (e.g. a lose screen).
- One sub-module, vga_frame_tick:
  - Contains the vs_d register and the falling-edge detect.
  - Ports: clk, resetn, vga_vs, fe.
  - Reused by other frame-synchronous blocks.
- FSM, counter and output registers live in vga_screen_ctrl.

Test Plan (HOLD_FRAMES = 4, MIN_FRAMES = 2, CNT_W = 8, one vga_vs low pulse every 20 clk):
- Reset released, no stimulus for 100 clk -> win = 0, game_pause = 0, busy = 0, game_restart never pulses.
- win_event at clk 5 with the next vs fall at clk 20:
  - game_pause = 1 at clk 6.
  - win = 1 at clk 21.
  - frame_cnt steps 1..4 on the following fe.
  - win = 0 and a single game_restart pulse one cycle after the fifth fe.
- continue_req held from frame_cnt = 1 -> no exit at frame_cnt 1; exits to GAME_PEND at frame_cnt = 2; win = 0 one cycle after the next fe.
- win_event in the same cycle as fe -> win stays 0 until the following fe, then goes to 1.
- Second win_event pulse during WIN_SHOW and again during GAME_PEND -> ignored; after return to GAME, exactly one game_restart and busy = 0.
- resetn = 0 for 1 cycle while in WIN_SHOW with frame_cnt = 3 -> next cycle win = 0, frame_cnt = 0, game_pause = 0, busy = 0.
